// File: rtl/inorder_issue_queue_if.sv
// Enqueue (rename side) and dequeue (memory-pipe side) handshake bundle for inorder_issue_queue.
interface inorder_issue_queue_if #(
  parameter int ENQ_W     = 2,
  parameter int AL_W      = 5,
  parameter int PR_W      = 6,
  parameter int PAYLOAD_W = 72
);
  logic [ENQ_W-1:0]           enq_valid;
  logic [ENQ_W*AL_W-1:0]      enq_al_addr;
  logic [ENQ_W*PR_W-1:0]      enq_rs1;
  logic [ENQ_W*PR_W-1:0]      enq_rs2;
  logic [ENQ_W-1:0]           enq_uses_rs1;
  logic [ENQ_W-1:0]           enq_uses_rs2;
  logic [ENQ_W-1:0]           enq_rs1_ready;
  logic [ENQ_W-1:0]           enq_rs2_ready;
  logic [ENQ_W*PAYLOAD_W-1:0] enq_payload;
  logic                       enq_ready;

  logic                       deq_valid;
  logic                       deq_ready;
  logic [AL_W-1:0]            deq_al_addr;
  logic [PR_W-1:0]            deq_rs1;
  logic [PR_W-1:0]            deq_rs2;
  logic                       deq_uses_rs1;
  logic                       deq_uses_rs2;
  logic [PAYLOAD_W-1:0]       deq_payload;

  modport master (
    output enq_valid, enq_al_addr, enq_rs1, enq_rs2, enq_uses_rs1, enq_uses_rs2,
           enq_rs1_ready, enq_rs2_ready, enq_payload, deq_ready,
    input  enq_ready, deq_valid, deq_al_addr, deq_rs1, deq_rs2, deq_uses_rs1,
           deq_uses_rs2, deq_payload
  );

  modport slave (
    input  enq_valid, enq_al_addr, enq_rs1, enq_rs2, enq_uses_rs1, enq_uses_rs2,
           enq_rs1_ready, enq_rs2_ready, enq_payload, deq_ready,
    output enq_ready, deq_valid, deq_al_addr, deq_rs1, deq_rs2, deq_uses_rs1,
           deq_uses_rs2, deq_payload
  );
endinterface

// File: rtl/inorder_issue_queue.sv
// In-order issue queue: multi-lane enqueue, wb snoop wakeup, head-only issue, age-based recall.
// Optional INORDER_IQ_WAKE_BYPASS_EN lets a same-cycle wb hit on the head sources enable issue.
module inorder_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int ENQ_W     = 2,
  parameter int NUM_WB    = 4,
  parameter int AL_W      = 5,
  parameter int PR_W      = 6,
  parameter int PAYLOAD_W = 72
) (
  input  logic                         clk,
  input  logic                         reset,
  inorder_issue_queue_if.slave         iq,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*PR_W-1:0]       wb_rd,
  input  logic                         recall,
  input  logic [AL_W-1:0]              recall_al_addr,
  input  logic [AL_W-1:0]              al_head,
  input  logic                         no_branches,
  input  logic [AL_W-1:0]              oldest_branch_al_addr,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [DEPTH-1:0]     valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [DEPTH-1:0]     uses1_q, uses1_d, uses2_q, uses2_d;
  logic [AL_W-1:0]      al_q  [DEPTH];
  logic [AL_W-1:0]      al_d  [DEPTH];
  logic [PR_W-1:0]      rs1_q [DEPTH];
  logic [PR_W-1:0]      rs1_d [DEPTH];
  logic [PR_W-1:0]      rs2_q [DEPTH];
  logic [PR_W-1:0]      rs2_d [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_d [DEPTH];
  ptr_t                 head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 enq_ok, head_nonspec, head_rs1_ok, head_rs2_ok, deq_valid_c, deq_fire;
  logic [DEPTH-1:0]     squash;
  logic [CNT_W-1:0]     n_squash, n_enq;
  ptr_t                 slot;

  function automatic logic wb_hit(input logic [PR_W-1:0] pr, input logic [NUM_WB-1:0] v,
                                  input logic [NUM_WB*PR_W-1:0] rd);
    logic h;
    h = 1'b0;
    for (int unsigned k = 0; k < NUM_WB; k++)
      if (v[k] && rd[k*PR_W +: PR_W] == pr) h = 1'b1;
    return h;
  endfunction

  function automatic logic [AL_W-1:0] age(input logic [AL_W-1:0] x, input logic [AL_W-1:0] h);
    return x - h;
  endfunction

  always_comb begin
    enq_ok       = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_W);
    head_nonspec = no_branches ||
                   (age(al_q[head_q], al_head) < age(oldest_branch_al_addr, al_head));
`ifdef INORDER_IQ_WAKE_BYPASS_EN
    head_rs1_ok  = rdy1_q[head_q] | wb_hit(rs1_q[head_q], wb_valid, wb_rd);
    head_rs2_ok  = rdy2_q[head_q] | wb_hit(rs2_q[head_q], wb_valid, wb_rd);
`else
    head_rs1_ok  = rdy1_q[head_q];
    head_rs2_ok  = rdy2_q[head_q];
`endif
    deq_valid_c  = valid_q[head_q] & head_rs1_ok & head_rs2_ok & head_nonspec & ~recall;
    deq_fire     = deq_valid_c & iq.deq_ready;
  end

  always_comb begin
    valid_d  = valid_q;
    uses1_d  = uses1_q;
    uses2_d  = uses2_q;
    al_d     = al_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    pay_d    = pay_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    n_squash = '0;
    n_enq    = '0;
    slot     = '0;
    squash   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rdy1_d[i] = rdy1_q[i] | (valid_q[i] & wb_hit(rs1_q[i], wb_valid, wb_rd));
      rdy2_d[i] = rdy2_q[i] | (valid_q[i] & wb_hit(rs2_q[i], wb_valid, wb_rd));
      squash[i] = valid_q[i] && (age(al_q[i], al_head) >= age(recall_al_addr, al_head));
      n_squash  = n_squash + CNT_W'(squash[i]);
    end
    // Program order equals AL order, so squashed entries are always the youngest tail run.
    if (recall) begin
      valid_d = valid_q & ~squash;
      tail_d  = tail_q - ptr_t'(n_squash);
      count_d = count_q - n_squash;
    end else begin
      if (deq_fire) begin
        valid_d[head_q] = 1'b0;
        rdy1_d[head_q]  = 1'b0;
        rdy2_d[head_q]  = 1'b0;
        head_d          = head_q + ptr_t'(1);
      end
      for (int unsigned i = 0; i < ENQ_W; i++) begin
        if (iq.enq_valid[i] && enq_ok) begin
          slot          = tail_q + ptr_t'(i);
          valid_d[slot] = 1'b1;
          al_d[slot]    = iq.enq_al_addr[i*AL_W +: AL_W];
          rs1_d[slot]   = iq.enq_rs1[i*PR_W +: PR_W];
          rs2_d[slot]   = iq.enq_rs2[i*PR_W +: PR_W];
          uses1_d[slot] = iq.enq_uses_rs1[i];
          uses2_d[slot] = iq.enq_uses_rs2[i];
          pay_d[slot]   = iq.enq_payload[i*PAYLOAD_W +: PAYLOAD_W];
          rdy1_d[slot]  = iq.enq_rs1_ready[i] | ~iq.enq_uses_rs1[i] |
                          wb_hit(iq.enq_rs1[i*PR_W +: PR_W], wb_valid, wb_rd);
          rdy2_d[slot]  = iq.enq_rs2_ready[i] | ~iq.enq_uses_rs2[i] |
                          wb_hit(iq.enq_rs2[i*PR_W +: PR_W], wb_valid, wb_rd);
          n_enq         = n_enq + CNT_W'(1);
        end
      end
      tail_d  = tail_q + ptr_t'(n_enq);
      count_d = count_q + n_enq - CNT_W'(deq_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      uses1_q <= '0;
      uses2_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        al_q[i]  <= '0;
        rs1_q[i] <= '0;
        rs2_q[i] <= '0;
        pay_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      uses1_q <= uses1_d;
      uses2_q <= uses2_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      al_q    <= al_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      pay_q   <= pay_d;
    end
  end

  // Enqueue lanes must be filled from lane 0 upward with no gaps.
  always_ff @(posedge clk) begin
    if (!reset) assert ((iq.enq_valid & (iq.enq_valid + ENQ_W'(1))) == '0);
  end

  assign iq.enq_ready    = enq_ok;
  assign iq.deq_valid    = deq_valid_c;
  assign iq.deq_al_addr  = al_q[head_q];
  assign iq.deq_rs1      = rs1_q[head_q];
  assign iq.deq_rs2      = rs2_q[head_q];
  assign iq.deq_uses_rs1 = uses1_q[head_q];
  assign iq.deq_uses_rs2 = uses2_q[head_q];
  assign iq.deq_payload  = pay_q[head_q];
  assign count           = count_q;
  assign full            = count_q == CNT_W'(DEPTH);
  assign empty           = count_q == '0;
endmodule

// File: tb/tb_inorder_issue_queue.sv
// Directed vector bench for inorder_issue_queue (DEPTH=8, ENQ_W=2, NUM_WB=4, AL_W=5, PR_W=6).
module tb_inorder_issue_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  wb_valid;
  logic [23:0] wb_rd;
  logic        recall;
  logic [4:0]  recall_al_addr, al_head, oldest_branch_al_addr;
  logic        no_branches;
  logic [3:0]  count;
  logic        full, empty;

  int n_vec  = 0;
  int n_miss = 0;

  inorder_issue_queue_if #(.ENQ_W(2), .AL_W(5), .PR_W(6), .PAYLOAD_W(72)) qif ();

  inorder_issue_queue #(
    .DEPTH(8), .ENQ_W(2), .NUM_WB(4), .AL_W(5), .PR_W(6), .PAYLOAD_W(72)
  ) dut (
    .clk(clk), .reset(reset), .iq(qif),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .recall(recall), .recall_al_addr(recall_al_addr), .al_head(al_head),
    .no_branches(no_branches), .oldest_branch_al_addr(oldest_branch_al_addr),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] ev;
    logic [4:0] a0, a1;
    logic       dr, rc;
    logic [4:0] rc_al, hd;
    logic       nb;
    logic [4:0] ob;
    logic       chk;
    logic       e_er, e_dv;
    logic [4:0] e_al;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic logic [71:0] pay(input logic [4:0] al);
    return {8'hC3, 59'd0, al};
  endfunction

  task automatic add(input logic rst, input logic [1:0] ev, input int a0, input int a1,
                     input logic dr, input logic rc, input int rc_al, input int hd,
                     input logic nb, input int ob, input logic chk, input logic e_er,
                     input logic e_dv, input int e_al, input int e_cnt);
    vec_t v;
    v.rst = rst; v.ev = ev; v.a0 = 5'(a0); v.a1 = 5'(a1); v.dr = dr; v.rc = rc;
    v.rc_al = 5'(rc_al); v.hd = 5'(hd); v.nb = nb; v.ob = 5'(ob); v.chk = chk;
    v.e_er = e_er; v.e_dv = e_dv; v.e_al = 5'(e_al); v.e_cnt = 4'(e_cnt);
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    qif.enq_valid = '0; qif.enq_al_addr = '0; qif.enq_rs1 = '0; qif.enq_rs2 = '0;
    qif.enq_uses_rs1 = '0; qif.enq_uses_rs2 = '0; qif.enq_rs1_ready = '0;
    qif.enq_rs2_ready = '0; qif.enq_payload = '0; qif.deq_ready = 1'b0;
    wb_valid = '0; wb_rd = '0; recall = 1'b0; recall_al_addr = '0;
    al_head = '0; no_branches = 1'b1; oldest_branch_al_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    idle();
    reset                 = v.rst;
    qif.enq_valid         = v.ev;
    qif.enq_al_addr       = {v.a1, v.a0};
    qif.enq_rs1           = {6'(v.a1) + 6'd1, 6'(v.a0) + 6'd1};
    qif.enq_rs2           = {6'(v.a1) + 6'd2, 6'(v.a0) + 6'd2};
    qif.enq_uses_rs1      = 2'b11;
    qif.enq_uses_rs2      = 2'b11;
    qif.enq_rs1_ready     = 2'b11;
    qif.enq_rs2_ready     = 2'b11;
    qif.enq_payload       = {pay(v.a1), pay(v.a0)};
    qif.deq_ready         = v.dr;
    recall                = v.rc;
    recall_al_addr        = v.rc_al;
    al_head               = v.hd;
    no_branches           = v.nb;
    oldest_branch_al_addr = v.ob;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // rst ev a0 a1 dr rc rcal hd nb ob chk | er dv al cnt
    add(1,3, 7, 8,1,1,0, 0,1,0,0, 0,0, 0,0);
    add(1,3, 7, 8,1,1,0, 0,1,0,1, 1,0, 0,0);
    add(1,3, 9, 9,0,0,0, 0,0,0,1, 1,0, 0,0);
    add(0,3, 3, 4,1,0,0, 0,1,0,1, 1,0, 0,0);
    add(0,0, 0, 0,1,0,0, 0,1,0,1, 1,1, 3,2);
    add(0,0, 0, 0,1,0,0, 0,1,0,1, 1,1, 4,1);
    add(0,0, 0, 0,1,0,0, 0,1,0,1, 1,0, 0,0);
    add(0,3,10,11,0,0,0, 0,1,0,1, 1,0, 0,0);
    add(0,3,12,13,0,0,0, 0,1,0,1, 1,1,10,2);
    add(0,3,14,15,0,0,0, 0,1,0,1, 1,1,10,4);
    add(0,3,16,17,0,0,0, 0,1,0,1, 1,1,10,6);
    add(0,3,20,21,0,0,0, 0,1,0,1, 0,1,10,8);
    add(0,0, 0, 0,1,0,0, 0,1,0,1, 0,1,10,8);
    add(0,3,20,21,0,0,0, 0,1,0,1, 0,1,11,7);
    for (int k = 0; k < 7; k++)
      add(0,0,0,0,1,0,0,0,1,0,1, (7-k) <= 6, 1, 11+k, 7-k);
    add(0,0, 0, 0,0,0,0, 0,1,0,1, 1,0, 0,0);
    add(0,3, 5, 6,0,0,0, 2,1,0,1, 1,0, 0,0);
    add(0,3, 7, 8,0,0,0, 2,1,0,1, 1,1, 5,2);
    add(0,1, 9, 0,0,0,0, 2,1,0,1, 1,1, 5,4);
    add(0,3,30,30,1,1,7, 2,1,0,1, 1,0, 0,5);
    add(0,1,10, 0,0,0,0, 2,1,0,1, 1,1, 5,2);
    add(0,0, 0, 0,1,0,0, 2,1,0,1, 1,1, 5,3);
    add(0,0, 0, 0,1,0,0, 2,1,0,1, 1,1, 6,2);
    add(0,0, 0, 0,1,0,0, 2,1,0,1, 1,1,10,1);
    add(0,0, 0, 0,0,0,0, 2,1,0,1, 1,0, 0,0);
    add(0,3,31, 0,0,0,0,30,0,0,1, 1,0, 0,0);
    add(0,1, 1, 0,0,0,0,30,0,0,1, 1,1,31,2);
    add(0,0, 0, 0,1,0,0,30,0,0,1, 1,1,31,3);
    add(0,0, 0, 0,1,0,0,30,0,0,1, 1,0, 0,2);
    add(0,0, 0, 0,1,0,0,30,1,0,1, 1,1, 0,2);
    add(0,0, 0, 0,1,0,0,30,1,0,1, 1,1, 1,1);
    add(0,0, 0, 0,0,0,0,30,1,0,1, 1,0, 0,0);
    add(0,3,31, 0,0,0,0,30,1,0,1, 1,0, 0,0);
    add(0,1, 1, 0,0,0,0,30,1,0,1, 1,1,31,2);
    add(0,0, 0, 0,1,1,0,30,1,0,1, 1,0, 0,3);
    add(0,0, 0, 0,1,0,0,30,1,0,1, 1,1,31,1);
    add(0,0, 0, 0,0,0,0,30,1,0,1, 1,0, 0,0);

    for (int r = 0; r < vq.size(); r++) begin
      drive(vq[r]);
      @(negedge clk);
      if (vq[r].chk) begin
        check($sformatf("r%0d enq_ready", r), 128'(qif.enq_ready), 128'(vq[r].e_er));
        check($sformatf("r%0d deq_valid", r), 128'(qif.deq_valid), 128'(vq[r].e_dv));
        check($sformatf("r%0d count", r), 128'(count), 128'(vq[r].e_cnt));
        check($sformatf("r%0d full", r), 128'(full), 128'(vq[r].e_cnt == 4'd8));
        check($sformatf("r%0d empty", r), 128'(empty), 128'(vq[r].e_cnt == 4'd0));
        if (vq[r].e_dv) begin
          check($sformatf("r%0d deq_al", r), 128'(qif.deq_al_addr), 128'(vq[r].e_al));
          check($sformatf("r%0d deq_rs1", r), 128'(qif.deq_rs1), 128'(6'(vq[r].e_al) + 6'd1));
          check($sformatf("r%0d deq_payload", r), 128'(qif.deq_payload), 128'(pay(vq[r].e_al)));
        end
      end
      @(posedge clk); #1;
    end

    // Wakeup via writeback port 2 while the op waits at the head.
    idle(); reset = 1'b0;
    qif.enq_valid = 2'b01; qif.enq_al_addr = 10'd2; qif.enq_rs1 = 12'd12;
    qif.enq_uses_rs1 = 2'b01; qif.enq_payload = {72'd0, pay(5'd2)};
    wb_valid = 4'b0010; wb_rd[6 +: 6] = 6'd13;
    @(negedge clk); check("wk count0", 128'(count), 128'd0);
    @(posedge clk); #1;
    idle();
    @(negedge clk); check("wk not_ready", 128'(qif.deq_valid), 128'd0);
    check("wk count1", 128'(count), 128'd1);
    @(posedge clk); #1;
    @(negedge clk); check("wk still_waiting", 128'(qif.deq_valid), 128'd0);
    @(posedge clk); #1;
    wb_valid = 4'b0100; wb_rd[12 +: 6] = 6'd12;
    @(negedge clk);
`ifdef INORDER_IQ_WAKE_BYPASS_EN
    check("wk same_cycle", 128'(qif.deq_valid), 128'd1);
`else
    check("wk same_cycle", 128'(qif.deq_valid), 128'd0);
`endif
    @(posedge clk); #1;
    idle(); qif.deq_ready = 1'b1;
    @(negedge clk); check("wk next_cycle", 128'(qif.deq_valid), 128'd1);
    check("wk al", 128'(qif.deq_al_addr), 128'd2);
    @(posedge clk); #1;
    idle();
    @(negedge clk); check("wk drained", 128'(empty), 128'd1);
    @(posedge clk); #1;

    // Writeback hit in the enqueue cycle is captured into the entry.
    qif.enq_valid = 2'b01; qif.enq_al_addr = 10'd3; qif.enq_rs2 = 12'd20;
    qif.enq_uses_rs2 = 2'b01; qif.enq_payload = {72'd0, pay(5'd3)};
    wb_valid = 4'b0001; wb_rd[0 +: 6] = 6'd20;
    @(posedge clk); #1;
    idle(); qif.deq_ready = 1'b1;
    @(negedge clk); check("cap deq_valid", 128'(qif.deq_valid), 128'd1);
    check("cap al", 128'(qif.deq_al_addr), 128'd3);
    @(posedge clk); #1;
    idle();
    @(negedge clk); check("cap drained", 128'(empty), 128'd1);
    @(posedge clk); #1;

    // Reset clears head data as well as control state.
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst deq_al", 128'(qif.deq_al_addr), 128'd0);
    check("rst deq_rs2", 128'(qif.deq_rs2), 128'd0);
    check("rst deq_payload", 128'(qif.deq_payload), 128'd0);
    check("rst enq_ready", 128'(qif.enq_ready), 128'd1);
    check("rst count", 128'(count), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
